gb_bus_sync: RTL and testbench

GB_BUS_SYNC -- requirements
Module: gb_bus_sync

---
 rtl/gb_bus_sync.sv | 171 +++++++++++++++++
 tb/tb_gb_bus_sync.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_bus_sync.sv
// gb_bus_sync: synchronizes the cartridge bus and qualifies write strobes.
// Accepted register-space writes are queued as {addr,data} events in a FIFO.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   GB_A, GB_D, GB_WR  async cartridge bus (A[15:12], D, active-low WR)
//   ev_addr, ev_data   head event; zero while the FIFO is empty
//   ev_valid, ev_ready head handshake, pop on valid & ready
//   ovf, ovf_clr       sticky drop flag and its synchronous clear
//   busy               write FSM is not idle
module gb_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] GB_A,
  input  logic [7:0] GB_D,
  input  logic       GB_WR,
  output logic [3:0] ev_addr,
  output logic [7:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MIN_LOW_C = 4'(MIN_LOW);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    LOW_CNT,
    ARMED
  } state_t;

  logic [SYNC_STAGES-1:0]      wr_sync;
  logic [SYNC_STAGES-1:0]      primed_sr;
  logic [SYNC_STAGES-1:0][3:0] a_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;

  logic       wr_s;
  logic [3:0] a_s;
  logic [7:0] d_s;
  logic       primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync   <= '1;
      a_sync    <= '0;
      d_sync    <= '0;
      primed_sr <= '0;
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], GB_WR};
      a_sync    <= {a_sync[SYNC_STAGES-2:0], GB_A};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], GB_D};
      primed_sr <= {primed_sr[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign a_s  = a_sync[SYNC_STAGES-1];
  assign d_s  = d_sync[SYNC_STAGES-1];
  // The reset value of the chain is not a pin sample; only trust wr_s
  // as "seen high" once a real sample has reached the last stage.
  assign primed = primed_sr[SYNC_STAGES-1];

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] hold_a;
  logic [7:0] hold_d;
  logic       push_try;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push_try  = 1'b0;
    unique case (state)
      WAIT_HIGH: begin
        if (wr_s && primed) state_nxt = IDLE;
      end
      IDLE: begin
        if (!wr_s) begin
          cnt_nxt   = 4'd1;
          state_nxt = (MIN_LOW == 1) ? ARMED : LOW_CNT;
        end
      end
      LOW_CNT: begin
        if (wr_s) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (cnt_nxt == MIN_LOW_C) state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (wr_s) begin
          push_try  = !hold_a[3];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  // Capturing on every low cycle means the hold register always carries
  // the last low-cycle sample, even when the strobe is exactly MIN_LOW long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a <= '0;
      hold_d <= '0;
    end else if (!wr_s) begin
      hold_a <= a_s;
      hold_d <= d_s;
    end
  end

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push, drop;

  assign full = (count == FULL_C);
  assign pop  = ev_valid && ev_ready;
  assign push = push_try && (!full || pop);
  assign drop = push_try && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {hold_a, hold_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign ev_valid = (count != '0);
  assign ev_addr  = ev_valid ? mem[rd_ptr][11:8] : 4'h0;
  assign ev_data  = ev_valid ? mem[rd_ptr][7:0]  : 8'h00;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gb_bus_sync.sv
// tb_gb_bus_sync: vector table, directed corner sequences and random writes
// checked against a pin-level event model with a queue-based FIFO.
module tb_gb_bus_sync;

  localparam int SYNC = 2;
  localparam int MINL = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] GB_A = '0;
  logic [7:0] GB_D = '0;
  logic       GB_WR = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] ev_addr;
  logic [7:0] ev_data;
  logic       ev_valid, ovf, busy;

  gb_bus_sync #(
    .SYNC_STAGES(SYNC),
    .MIN_LOW(MINL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .GB_A(GB_A), .GB_D(GB_D), .GB_WR(GB_WR),
    .ev_addr(ev_addr), .ev_data(ev_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    int         t;
    logic [3:0] a;
    logic [7:0] d;
  } pend_t;

  ev_t   mq[$];
  pend_t pq[$];
  int    edge_n = 0;
  bit    seen_high = 0;
  int    low_run = 0;
  logic [3:0] last_a = '0;
  logic [7:0] last_d = '0;
  logic  m_ovf = 1'b0;
  bit    rnd = 0;

  // One clock edge: advance the model, then compare all observable outputs.
  task automatic step();
    bit    do_pop, do_push, drop;
    pend_t pe;
    ev_t   e;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      mq.delete();
      pq.delete();
      m_ovf = 1'b0;
      seen_high = 0;
      low_run = 0;
    end else begin
      do_pop = (mq.size() > 0) && ev_ready;
      do_push = 0;
      if (pq.size() > 0 && pq[0].t == edge_n) begin
        pe = pq.pop_front();
        do_push = 1;
      end
      drop = do_push && (mq.size() == DEPTH) && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push && !drop) begin
        e.a = pe.a;
        e.d = pe.d;
        mq.push_back(e);
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      // A pin rise seen at edge n reaches the FSM SYNC edges later.
      if (GB_WR) begin
        if (seen_high && low_run >= MINL && !last_a[3]) begin
          pe.t = edge_n + SYNC;
          pe.a = last_a;
          pe.d = last_d;
          pq.push_back(pe);
        end
        seen_high = 1;
        low_run = 0;
      end else if (seen_high) begin
        low_run++;
        last_a = GB_A;
        last_d = GB_D;
      end
    end
    #1;
    chk("m_valid", ev_valid, mq.size() > 0);
    chk("m_addr", ev_addr, mq.size() > 0 ? mq[0].a : 4'h0);
    chk("m_data", ev_data, mq.size() > 0 ? mq[0].d : 8'h00);
    chk("m_ovf", ovf, m_ovf);
    if (rnd) begin
      ev_ready = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input int low, input int gap);
    GB_A = a;
    GB_D = d;
    GB_WR = 1'b0;
    repeat (low) step();
    GB_WR = 1'b1;
    repeat (gap) step();
  endtask

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         low;
    bit         ev;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{4'h2, 8'h05, 6, 1'b1};
    vt[1] = '{4'h3, 8'hFF, 3, 1'b1};
    vt[2] = '{4'h3, 8'h11, 2, 1'b0};
    vt[3] = '{4'hA, 8'h0A, 6, 1'b0};
    vt[4] = '{4'h7, 8'h80, 4, 1'b1};
    vt[5] = '{4'h8, 8'h12, 5, 1'b0};
    vt[6] = '{4'h0, 8'h3C, 1, 1'b0};
    vt[7] = '{4'h0, 8'hC3, 9, 1'b1};

    #1 rst = 1'b1;
    step();
    step();
    chk("rst_valid", ev_valid, 1'b0);
    chk("rst_addr", ev_addr, 4'h0);
    chk("rst_data", ev_data, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b1);
    rst = 1'b0;
    repeat (6) step();
    chk("idle_busy", busy, 1'b0);

    GB_A = 4'h2;
    GB_D = 8'h05;
    GB_WR = 1'b0;
    repeat (6) step();
    GB_WR = 1'b1;
    step();
    chk("lat_e1", ev_valid, 1'b0);
    step();
    chk("lat_e2", ev_valid, 1'b0);
    step();
    chk("lat_e3", ev_valid, 1'b1);
    chk("lat_addr", ev_addr, 4'h2);
    chk("lat_data", ev_data, 8'h05);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    repeat (4) step();
    chk("lat_once", ev_valid, 1'b0);

    foreach (vt[i]) begin
      wr(vt[i].a, vt[i].d, vt[i].low, 2);
      repeat (5) step();
      chk("vec_valid", ev_valid, vt[i].ev);
      if (vt[i].ev) begin
        chk("vec_addr", ev_addr, vt[i].a);
        chk("vec_data", ev_data, vt[i].d);
      end
      chk("vec_ovf", ovf, 1'b0);
      chk("vec_busy", busy, 1'b0);
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      step();
      chk("vec_empty", ev_valid, 1'b0);
    end

    GB_A = 4'h3;
    GB_D = 8'h11;
    GB_WR = 1'b0;
    repeat (4) step();
    GB_D = 8'h22;
    step();
    GB_WR = 1'b1;
    repeat (5) step();
    chk("late_d", ev_data, 8'h22);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;

    for (int i = 0; i < 5; i++) wr(4'h3, 8'(i), 4, 3);
    repeat (4) step();
    chk("full_ovf", ovf, 1'b1);
    chk("full_valid", ev_valid, 1'b1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", ev_data, 8'(i));
      step();
    end
    ev_ready = 1'b0;
    chk("drained", ev_valid, 1'b0);
    chk("ovf_hold", ovf, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 1'b0);

    for (int i = 0; i < 4; i++) wr(4'h1, 8'(8'h40 + i), 4, 3);
    GB_A = 4'h1;
    GB_D = 8'h99;
    GB_WR = 1'b0;
    repeat (4) step();
    GB_WR = 1'b1;
    step();
    step();
    ovf_clr = 1'b1;
    step();
    chk("set_wins", ovf, 1'b1);
    step();
    chk("clr_after", ovf, 1'b0);
    ovf_clr = 1'b0;
    chk("keep_head", ev_data, 8'h40);
    ev_ready = 1'b1;
    repeat (5) step();
    ev_ready = 1'b0;

    GB_A = 4'h4;
    GB_D = 8'h38;
    GB_WR = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    step();
    chk("rst_mid_busy", busy, 1'b1);
    chk("rst_mid_valid", ev_valid, 1'b0);
    rst = 1'b0;
    repeat (4) step();
    GB_WR = 1'b1;
    repeat (6) step();
    chk("rst_no_ev", ev_valid, 1'b0);
    chk("rst_idle", busy, 1'b0);
    wr(4'h5, 8'h55, 4, 6);
    chk("rst_next_v", ev_valid, 1'b1);
    chk("rst_next_d", ev_data, 8'h55);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    step();
    chk("rst_next_1", ev_valid, 1'b0);

    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      wr(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
         $urandom_range(1, 6), $urandom_range(1, 4));
    end
    rnd = 0;
    ovf_clr = 1'b0;
    ev_ready = 1'b1;
    repeat (10) step();
    chk("rnd_drain", ev_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
